parity_engine: RTL and testbench
================================

Name: parity_engine

Overview:
Parametrised successor to the UART parity calculator for the TX and RX paths. It latches a data word with a valid strobe and folds parity bit-serially over a runtime-selectable data length. It supports even, odd, mark and space parity, and can optionally check a received parity bit. It signals completion with a one-cycle PAR_VLD pulse and exposes BUSY so the frame FSM can pace words.

Parameters:
DATA_W, 8, maximum data word width in bits (>=5)
LEN_W, 4, width of DATA_LEN; must satisfy 2**LEN_W > DATA_W
ERR_CNT_W, 8, width of the parity-error counter (optional feature only)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
P_DATA  in  DATA_W  data word; bit 0 is transmitted first
DATA_VLD  in  1  request to accept P_DATA
PAR_EN  in  1  parity enabled; DATA_VLD is ignored when low
PAR_TYP  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
DATA_LEN  in  LEN_W  number of valid low-order data bits
CHK_EN  in  1  compare the result against RX_PAR_BIT at completion
RX_PAR_BIT  in  1  received parity bit (RX path)
FLUSH  in  1  synchronous abort of the current operation
BUSY  out  1  high while in CALC
PAR_BIT  out  1  computed parity bit; held until the next completion
PAR_VLD  out  1  one-cycle completion pulse
PAR_ERR  out  1  parity mismatch flag; held until the next completion
ERR_CNT  out  ERR_CNT_W  saturating error count (optional feature)

Behaviour:
- Reset, asynchronous with RST=0: state IDLE; shift register, accumulator and counter cleared; BUSY=0, PAR_BIT=0, PAR_VLD=0, PAR_ERR=0, ERR_CNT=0.
- States: IDLE and CALC.
- IDLE -> CALC when DATA_VLD=1, PAR_EN=1 and FLUSH=0 at an edge (the accept edge e0).
  - At e0, latch P_DATA, PAR_TYP and the effective length L.
  - L = DATA_LEN if 1 <= DATA_LEN <= DATA_W; otherwise L = DATA_W.
- CALC, edges e1..eL, one bit per edge: acc ^= sreg[0]; sreg shifts right; cnt increments.
- At edge eL:
  - State returns to IDLE and PAR_VLD<=1 for exactly one cycle.
  - PAR_BIT <= acc_final for even, ~acc_final for odd, 1 for mark, 0 for space.
  - PAR_ERR <= CHK_EN & (final PAR_BIT != RX_PAR_BIT); CHK_EN and RX_PAR_BIT are sampled at eL.
- Latency: PAR_VLD is visible from eL to eL+1. Mark/space use the same latency as even/odd.
- BUSY is asserted from e0 to eL.
  - DATA_VLD during CALC is ignored; it is neither queued nor counted.
  - Back-to-back operation: a new word can be accepted at eL+1.
- PAR_EN=0 in IDLE: DATA_VLD is ignored and outputs hold. A PAR_EN change during CALC has no effect.
- FLUSH=1 at any edge:
  - state <- IDLE, counter and accumulator cleared, PAR_VLD <= 0;
  - PAR_BIT and PAR_ERR hold their previous values;
  - FLUSH wins over a simultaneous DATA_VLD and over completion at eL.
- Inputs that change during CALC (P_DATA, DATA_LEN, PAR_TYP) do not affect the operation in flight.
- Bits of P_DATA above L-1 never contribute to parity.

Optional Feature:
Macro PARITY_ERR_CNT_EN.
- Defined: ERR_CNT increments by 1 at each completion that sets PAR_ERR=1, saturates at 2**ERR_CNT_W-1, and is cleared by FLUSH or reset.
- Undefined: the port remains, ERR_CNT is tied to 0, and no counter logic is built.

Test Plan:
- DATA_LEN=8, P_DATA=8'hA5, PAR_TYP=00, DATA_VLD pulse -> BUSY high for 8 cycles, PAR_VLD single pulse 8 cycles after accept, PAR_BIT=0; repeat with PAR_TYP=01 -> PAR_BIT=1.
- DATA_LEN=7, P_DATA=8'h81, even -> PAR_BIT=1 (bit 7 excluded); DATA_LEN=0 -> treated as 8 -> PAR_BIT=0; mark -> 1; space -> 0.
- CHK_EN=1, P_DATA=8'hA5 even, RX_PAR_BIT=1 -> PAR_ERR=1; next word with matching RX_PAR_BIT -> PAR_ERR returns to 0.
- FLUSH asserted at the 4th CALC cycle -> no PAR_VLD, BUSY low next cycle, PAR_BIT keeps its previous value; FLUSH together with DATA_VLD in IDLE -> nothing accepted.
- Back-to-back words 8'h01 then 8'h03 (even, L=8), with the second DATA_VLD held from e1 -> second accept at e9, PAR_VLD pulses at e8 (PAR_BIT=1) and e17 (PAR_BIT=0).
- PARITY_ERR_CNT_EN defined, ERR_CNT_W=2, five mismatching words -> ERR_CNT 1,2,3,3,3; FLUSH -> ERR_CNT=0.

Source files
------------

// File: rtl/parity_engine_if.sv
// Handshake/bus bundle for parity_engine: word request, mode controls and completion outputs.
// The slave modport is the engine side; the master modport is the frame FSM or bench side.
interface parity_engine_if #(
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [DATA_W-1:0]    P_DATA;
    logic                 DATA_VLD;
    logic                 PAR_EN;
    logic [1:0]           PAR_TYP;
    logic [LEN_W-1:0]     DATA_LEN;
    logic                 CHK_EN;
    logic                 RX_PAR_BIT;
    logic                 FLUSH;
    logic                 BUSY;
    logic                 PAR_BIT;
    logic                 PAR_VLD;
    logic                 PAR_ERR;
    logic [ERR_CNT_W-1:0] ERR_CNT;
    logic                 STATE_DBG;

    // Request semantics: DATA_VLD is a level request, taken on any edge where
    // the engine is IDLE, PAR_EN=1 and FLUSH=0; BUSY=1 means the request is
    // ignored (not queued). PAR_VLD is a single-cycle result strobe that has
    // no back-pressure; PAR_BIT/PAR_ERR stay valid until the next completion.
    modport master (
        output P_DATA, DATA_VLD, PAR_EN, PAR_TYP, DATA_LEN, CHK_EN, RX_PAR_BIT, FLUSH,
        input  BUSY, PAR_BIT, PAR_VLD, PAR_ERR, ERR_CNT, STATE_DBG
    );

    modport slave (
        input  P_DATA, DATA_VLD, PAR_EN, PAR_TYP, DATA_LEN, CHK_EN, RX_PAR_BIT, FLUSH,
        output BUSY, PAR_BIT, PAR_VLD, PAR_ERR, ERR_CNT, STATE_DBG
    );
endinterface

// File: rtl/parity_engine.sv
// Bit-serial UART parity engine (even/odd/mark/space, optional RX check).
// Optional saturating error counter enabled by defining PARITY_ERR_CNT_EN.
module parity_engine #(
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    parity_engine_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sreg, sreg_nxt;
    logic              acc, acc_nxt;
    logic [LEN_W-1:0]  cnt, cnt_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [1:0]        typ_q, typ_nxt;
    logic              par_bit, par_bit_nxt;
    logic              par_vld, par_vld_nxt;
    logic              par_err, par_err_nxt;

    logic              acc_step;
    logic [LEN_W-1:0]  cnt_step;
    logic [LEN_W-1:0]  len_eff;
    logic              final_bit;

    // Out-of-range lengths (0 or above DATA_W) fall back to the full word.
    always_comb begin
        if ((bus.DATA_LEN != '0) && (bus.DATA_LEN <= FULL_LEN)) begin
            len_eff = bus.DATA_LEN;
        end else begin
            len_eff = FULL_LEN;
        end
    end

    always_comb begin
        acc_step = acc ^ sreg[0];
        cnt_step = cnt + 1'b1;
        case (typ_q)
            2'b00:   final_bit = acc_step;
            2'b01:   final_bit = ~acc_step;
            2'b10:   final_bit = 1'b1;
            default: final_bit = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            sreg    <= '0;
            acc     <= 1'b0;
            cnt     <= '0;
            len_q   <= '0;
            typ_q   <= 2'b00;
            par_bit <= 1'b0;
            par_vld <= 1'b0;
            par_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            len_q   <= len_nxt;
            typ_q   <= typ_nxt;
            par_bit <= par_bit_nxt;
            par_vld <= par_vld_nxt;
            par_err <= par_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        len_nxt     = len_q;
        typ_nxt     = typ_q;
        par_bit_nxt = par_bit;
        par_vld_nxt = 1'b0;
        par_err_nxt = par_err;

        // FLUSH dominates both a new request and the completing edge.
        if (bus.FLUSH) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            acc_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.DATA_VLD && bus.PAR_EN) begin
                        state_nxt = CALC;
                        sreg_nxt  = bus.P_DATA;
                        len_nxt   = len_eff;
                        typ_nxt   = bus.PAR_TYP;
                        cnt_nxt   = '0;
                        acc_nxt   = 1'b0;
                    end
                end
                CALC: begin
                    acc_nxt  = acc_step;
                    sreg_nxt = sreg >> 1;
                    cnt_nxt  = cnt_step;
                    if (cnt_step == len_q) begin
                        state_nxt   = IDLE;
                        par_vld_nxt = 1'b1;
                        par_bit_nxt = final_bit;
                        par_err_nxt = bus.CHK_EN & (final_bit != bus.RX_PAR_BIT);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt <= '0;
        end else if (bus.FLUSH) begin
            err_cnt <= '0;
        end else if (par_vld_nxt && par_err_nxt && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.ERR_CNT = err_cnt;
`else
    assign bus.ERR_CNT = '0;
`endif

    assign bus.BUSY      = (state == CALC);
    assign bus.PAR_BIT   = par_bit;
    assign bus.PAR_VLD   = par_vld;
    assign bus.PAR_ERR   = par_err;
    assign bus.STATE_DBG = state;

endmodule

// File: tb/tb_parity_engine.sv
// Bench for parity_engine: completion-time reference model checked every cycle,
// directed literal scenarios, then randomized traffic.
module tb_parity_engine;

    localparam int DATA_W    = 8;
    localparam int LEN_W     = 4;
    localparam int ERR_CNT_W = 2;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    parity_engine_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

    parity_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int eff_len(input logic [LEN_W-1:0] len);
        if (len >= 1 && len <= DATA_W) return int'(len);
        return DATA_W;
    endfunction

    function automatic logic exp_parity(input logic [DATA_W-1:0] data, input int len,
                                        input logic [1:0] typ);
        int ones = 0;
        for (int i = 0; i < len; i++) ones += int'(data[i]);
        case (typ)
            2'b00:   return logic'(ones % 2);
            2'b01:   return logic'(1 - (ones % 2));
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    int   cyc;
    int   m_done;
    logic m_busy, m_vld, m_par, m_err, m_exp;
    int   m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_done = 0; m_busy = 0; m_vld = 0; m_par = 0; m_err = 0; m_exp = 0; m_cnt = 0;
        end else begin
            cyc++;
            m_vld = 0;
            if (bus.FLUSH) begin
                m_busy = 0;
                m_cnt  = 0;
            end else if (m_busy) begin
                if (cyc == m_done) begin
                    m_busy = 0;
                    m_vld  = 1;
                    m_par  = m_exp;
                    m_err  = bus.CHK_EN && (m_exp != bus.RX_PAR_BIT);
`ifdef PARITY_ERR_CNT_EN
                    if (m_err && m_cnt < CNT_MAX) m_cnt++;
`endif
                end
            end else if (bus.DATA_VLD && bus.PAR_EN) begin
                m_busy = 1;
                m_done = cyc + eff_len(bus.DATA_LEN);
                m_exp  = exp_parity(bus.P_DATA, eff_len(bus.DATA_LEN), bus.PAR_TYP);
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy",    32'(bus.BUSY),      32'(m_busy));
            check("state",   32'(bus.STATE_DBG), 32'(m_busy));
            check("par_vld", 32'(bus.PAR_VLD),   32'(m_vld));
            check("par_bit", 32'(bus.PAR_BIT),   32'(m_par));
            check("par_err", 32'(bus.PAR_ERR),   32'(m_err));
            check("err_cnt", 32'(bus.ERR_CNT),   32'(m_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.P_DATA = '0; bus.DATA_VLD = 0; bus.PAR_EN = 1; bus.PAR_TYP = 2'b00;
        bus.DATA_LEN = 4'd8; bus.CHK_EN = 0; bus.RX_PAR_BIT = 0; bus.FLUSH = 0;
    endtask

    task automatic send(input string name, input logic [7:0] data, input logic [3:0] len,
                        input logic [1:0] typ, input logic chk, input logic rx,
                        input logic exp_bit, input logic exp_err, input int exp_lat);
        int lat = 0;
        bit got = 0;
        @(posedge clk); #2;
        bus.P_DATA = data; bus.DATA_LEN = len; bus.PAR_TYP = typ;
        bus.CHK_EN = chk; bus.RX_PAR_BIT = rx; bus.DATA_VLD = 1;
        @(posedge clk); #2;
        bus.DATA_VLD = 0;
        repeat (40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.PAR_VLD) begin
                got = 1;
                break;
            end
        end
        check({name, "_got"}, 32'(got), 32'd1);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_bit"}, 32'(bus.PAR_BIT), 32'(exp_bit));
        check({name, "_err"}, 32'(bus.PAR_ERR), 32'(exp_err));
    endtask

    task automatic flush_cycle();
        @(posedge clk); #2;
        bus.FLUSH = 1;
        @(posedge clk); #2;
        bus.FLUSH = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int np;
        int pk[2];
        logic pb[2];
        int nvld;

        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_vld",  32'(bus.PAR_VLD), 32'd0);
        check("rst_bit",  32'(bus.PAR_BIT), 32'd0);
        check("rst_err",  32'(bus.PAR_ERR), 32'd0);
        check("rst_cnt",  32'(bus.ERR_CNT), 32'd0);
        rst_n = 1;

        check("model_81_l7", 32'(exp_parity(8'h81, eff_len(4'd7), 2'b00)), 32'd1);
        check("model_a5_odd", 32'(exp_parity(8'hA5, eff_len(4'd0), 2'b01)), 32'd1);

        send("a5_even",  8'hA5, 4'd8, 2'b00, 0, 0, 1'b0, 1'b0, 8);
        send("a5_odd",   8'hA5, 4'd8, 2'b01, 0, 0, 1'b1, 1'b0, 8);
        send("81_l7",    8'h81, 4'd7, 2'b00, 0, 0, 1'b1, 1'b0, 7);
        send("81_l0",    8'h81, 4'd0, 2'b00, 0, 0, 1'b0, 1'b0, 8);
        send("mark",     8'h81, 4'd8, 2'b10, 0, 0, 1'b1, 1'b0, 8);
        send("space",    8'hFF, 4'd8, 2'b11, 0, 0, 1'b0, 1'b0, 8);
        send("l12",      8'h01, 4'd12, 2'b00, 0, 0, 1'b1, 1'b0, 8);
        send("chk_bad",  8'hA5, 4'd8, 2'b00, 1, 1, 1'b0, 1'b1, 8);
        send("chk_good", 8'hA5, 4'd8, 2'b00, 1, 0, 1'b0, 1'b0, 8);

        // Flush at the 4th CALC cycle; PAR_BIT must keep the 1 from this word.
        send("pre_flush", 8'h01, 4'd8, 2'b00, 0, 0, 1'b1, 1'b0, 8);
        @(posedge clk); #2;
        bus.P_DATA = 8'h00; bus.DATA_VLD = 1;
        @(posedge clk); #2;
        bus.DATA_VLD = 0;
        repeat (2) @(posedge clk);
        #2 bus.FLUSH = 1;
        @(posedge clk); #2;
        bus.FLUSH = 0;
        @(negedge clk);
        check("flush_busy", 32'(bus.BUSY), 32'd0);
        nvld = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.PAR_VLD) nvld++;
        end
        check("flush_novld", 32'(nvld), 32'd0);
        check("flush_bit",   32'(bus.PAR_BIT), 32'd1);

        // FLUSH with DATA_VLD in IDLE accepts nothing.
        @(posedge clk); #2;
        bus.DATA_VLD = 1; bus.FLUSH = 1;
        @(posedge clk); #2;
        bus.DATA_VLD = 0; bus.FLUSH = 0;
        @(negedge clk);
        check("flush_dv_busy", 32'(bus.BUSY), 32'd0);

        // Back-to-back: second request held from e1, accepted at e9.
        np = 0;
        @(posedge clk); #2;
        bus.P_DATA = 8'h01; bus.DATA_LEN = 4'd8; bus.PAR_TYP = 2'b00; bus.DATA_VLD = 1;
        @(posedge clk); #2;
        bus.P_DATA = 8'h03;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            if (k == 9) begin
                #2 bus.DATA_VLD = 0;
            end
            @(negedge clk);
            if (bus.PAR_VLD) begin
                if (np < 2) begin
                    pk[np] = k;
                    pb[np] = bus.PAR_BIT;
                end
                np++;
            end
        end
        check("b2b_count", 32'(np), 32'd2);
        check("b2b_e1",    32'(pk[0]), 32'd8);
        check("b2b_bit1",  32'(pb[0]), 32'd1);
        check("b2b_e2",    32'(pk[1]), 32'd17);
        check("b2b_bit2",  32'(pb[1]), 32'd0);

`ifdef PARITY_ERR_CNT_EN
        begin
            int exp_cnt[5] = '{1, 2, 3, 3, 3};
            flush_cycle();
            for (int i = 0; i < 5; i++) begin
                send("cnt_word", 8'hA5, 4'd8, 2'b00, 1, 1, 1'b0, 1'b1, 8);
                check("err_cnt_lit", 32'(bus.ERR_CNT), 32'(exp_cnt[i]));
            end
            flush_cycle();
            @(negedge clk);
            check("err_cnt_flush", 32'(bus.ERR_CNT), 32'd0);
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            bus.P_DATA     = 8'($urandom);
            bus.DATA_VLD   = ($urandom_range(0, 3) != 0);
            bus.PAR_EN     = ($urandom_range(0, 7) != 0);
            bus.PAR_TYP    = 2'($urandom_range(0, 3));
            bus.DATA_LEN   = 4'($urandom_range(0, 15));
            bus.CHK_EN     = 1'($urandom_range(0, 1));
            bus.RX_PAR_BIT = 1'($urandom_range(0, 1));
            bus.FLUSH      = ($urandom_range(0, 40) == 0);
        end
        @(posedge clk); #2;
        idle_inputs();
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
